// File: rtl/run_stream_packer.sv
// Packs a binarised pixel stream into (start,end) runs plus line/frame markers
// in a first-word-fall-through FIFO. Optional macro: RUN_MIN_LEN_EN drops short runs.
module run_stream_packer #(
   parameter int COL_W       = 10,
   parameter int FIFO_DEPTH  = 32,
   parameter int MIN_RUN_LEN = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               end_frame_in,
   input  logic               end_line_in,
   input  logic               new_pixel,
   input  logic               pixel,
   input  logic               rd_en,
   output logic [2*COL_W:0]   dout,
   output logic               empty,
   output logic               full,
   output logic               overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = 2*COL_W + 1;
   localparam logic [COL_W-1:0] COL_MAX = '1;
   localparam logic [COL_W-1:0] COL_ONE = {{(COL_W-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0]    PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]      CNT_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [DW-1:0]    EOL_WORD = {1'b1, {(2*COL_W){1'b0}}};
   localparam logic [DW-1:0]    EOF_WORD = '1;

   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MIN_RUN_LEN < 1) begin : g_bad_cfg
      $error("run_stream_packer: FIFO_DEPTH must be a power of two >= 4 and MIN_RUN_LEN >= 1");
   end

   function automatic logic [COL_W-1:0] sat_inc(input logic [COL_W-1:0] v);
      return (v == COL_MAX) ? v : v + COL_ONE;
   endfunction

   function automatic logic run_keep(input logic [COL_W-1:0] s, input logic [COL_W-1:0] e);
`ifdef RUN_MIN_LEN_EN
      logic [COL_W:0] len;
      len = {1'b0, e} - {1'b0, s} + {{COL_W{1'b0}}, 1'b1};
      return len >= (COL_W+1)'(MIN_RUN_LEN);
`else
      return e >= s;
`endif
   endfunction

   // run detection state
   logic [COL_W-1:0] r_col;
   logic             r_sat;
   logic             r_in_run;
   logic [COL_W-1:0] r_start;

   // staged run awaiting its FIFO slot
   logic             r_run_vld_p1;
   logic             r_run_first_p1;
   logic [COL_W-1:0] r_run_start_p1;
   logic [COL_W-1:0] r_run_end_p1;
   logic             r_pend_eol;
   logic             r_pend_eof;

   // FIFO storage
   logic [DW-1:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [DW-1:0]    r_last;
   logic             r_overflow;

   logic             w_pulse;
   logic             w_pix;
   logic             w_open;
   logic             w_close_pix;
   logic             w_close_pulse;
   logic             w_close;
   logic [COL_W-1:0] w_close_end;
   logic             w_take_run;
   logic             w_take_eol;
   logic             w_take_eof;
   logic             w_wr_req;
   logic [DW-1:0]    w_wr_data;
   logic             w_rd;
   logic             w_wr;

   // Once the last column has been counted, later pixels are ignored so a run
   // touching that column can only be closed by a line/frame pulse.
   assign w_pulse       = end_line_in | end_frame_in;
   assign w_pix         = new_pixel & ~w_pulse & ~r_sat;
   assign w_open        = w_pix & pixel & ~r_in_run;
   assign w_close_pix   = w_pix & ~pixel & r_in_run;
   assign w_close_pulse = w_pulse & r_in_run;
   assign w_close       = w_close_pix | w_close_pulse;
   assign w_close_end   = (w_close_pulse && r_sat) ? COL_MAX : r_col - COL_ONE;

   // A run closed by the pulse precedes its markers; a later run waits behind them.
   assign w_take_run = r_run_vld_p1 & (r_run_first_p1 | ~(r_pend_eol | r_pend_eof));
   assign w_take_eol = ~w_take_run & r_pend_eol;
   assign w_take_eof = ~w_take_run & ~r_pend_eol & r_pend_eof;
   assign w_wr_req   = (w_take_run & run_keep(r_run_start_p1, r_run_end_p1))
                       | w_take_eol | w_take_eof;

   always_comb begin
      w_wr_data = EOF_WORD;
      if (w_take_run) begin
         w_wr_data = {1'b0, r_run_start_p1, r_run_end_p1};
      end else if (w_take_eol) begin
         w_wr_data = EOL_WORD;
      end
   end

   assign empty    = (r_count == '0);
   assign full     = (r_count == DEPTH_C);
   assign overflow = r_overflow;
   assign w_rd     = rd_en & ~empty;
   assign w_wr     = w_wr_req & (~full | w_rd);
   assign dout     = empty ? r_last : r_mem[r_rd_ptr];

   // stage p0: column counting and run tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col    <= '0;
         r_sat    <= 1'b0;
         r_in_run <= 1'b0;
      end else begin
         if (w_pulse) begin
            r_col    <= '0;
            r_sat    <= 1'b0;
            r_in_run <= 1'b0;
         end else begin
            if (new_pixel && !r_sat) begin
               r_col <= sat_inc(r_col);
               r_sat <= (r_col == COL_MAX);
            end
            if (w_open) begin
               r_in_run <= 1'b1;
            end else if (w_close_pix) begin
               r_in_run <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_open) begin
         r_start <= r_col;
      end
      if (w_close) begin
         r_run_start_p1 <= r_start;
         r_run_end_p1   <= w_close_end;
      end
   end

   // stage p1: staged run and pending markers feed the FIFO write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run_vld_p1   <= 1'b0;
         r_run_first_p1 <= 1'b0;
         r_pend_eol     <= 1'b0;
         r_pend_eof     <= 1'b0;
      end else begin
         if (w_close) begin
            r_run_vld_p1   <= 1'b1;
            r_run_first_p1 <= w_close_pulse;
         end else if (w_take_run) begin
            r_run_vld_p1   <= 1'b0;
            r_run_first_p1 <= 1'b0;
         end
         r_pend_eol <= (r_pend_eol & ~w_take_eol) | end_line_in;
         r_pend_eof <= (r_pend_eof & ~w_take_eof) | end_frame_in;
      end
   end

   // stage p2: FIFO
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= w_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_wr_req && full && !w_rd) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_run_stream_packer.sv
// Directed bench for run_stream_packer: a default-depth instance plus a depth-4
// instance used for the overflow case.
module tb_run_stream_packer;

   localparam logic [20:0] EOL = 21'h100000;
   localparam logic [20:0] EOF = 21'h1FFFFF;

   logic        clk;
   logic        rst;
   logic        end_frame_in;
   logic        end_line_in;
   logic        new_pixel;
   logic        pixel;
   logic        rd_en;
   logic        rd_en_s;
   logic [20:0] dout;
   logic        empty;
   logic        full;
   logic        overflow;
   logic [20:0] dout_s;
   logic        empty_s;
   logic        full_s;
   logic        overflow_s;

   int checks = 0;
   int errors = 0;

   run_stream_packer #(.COL_W(10), .FIFO_DEPTH(32), .MIN_RUN_LEN(2)) u_dut (
      .clk(clk), .rst(rst), .end_frame_in(end_frame_in), .end_line_in(end_line_in),
      .new_pixel(new_pixel), .pixel(pixel), .rd_en(rd_en),
      .dout(dout), .empty(empty), .full(full), .overflow(overflow)
   );

   run_stream_packer #(.COL_W(10), .FIFO_DEPTH(4), .MIN_RUN_LEN(2)) u_small (
      .clk(clk), .rst(rst), .end_frame_in(end_frame_in), .end_line_in(end_line_in),
      .new_pixel(new_pixel), .pixel(pixel), .rd_en(rd_en_s),
      .dout(dout_s), .empty(empty_s), .full(full_s), .overflow(overflow_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [20:0] run(input int s, input int e);
      logic [9:0] ss;
      logic [9:0] ee;
      ss = s[9:0];
      ee = e[9:0];
      return {1'b0, ss, ee};
   endfunction

   task automatic chk(input logic [20:0] obs, input logic [20:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic px(input logic b);
      new_pixel = 1'b1;
      pixel     = b;
      step();
      new_pixel = 1'b0;
      pixel     = 1'b0;
   endtask

   task automatic pxn(input logic b, input int n);
      repeat (n) px(b);
   endtask

   task automatic eol();
      end_line_in = 1'b1;
      step();
      end_line_in = 1'b0;
   endtask

   task automatic eof();
      end_frame_in = 1'b1;
      step();
      end_frame_in = 1'b0;
   endtask

   task automatic line();
      pxn(1'b0, 5); pxn(1'b1, 14); pxn(1'b0, 5); pxn(1'b1, 5); pxn(1'b0, 5);
      step();
   endtask

   task automatic pop(input logic [20:0] exp, input string tag);
      int n = 0;
      while (empty && n < 8) begin
         step();
         n++;
      end
      if (empty) begin
         chk({20'd0, empty}, 21'd0, tag);
      end else begin
         chk(dout, exp, tag);
         rd_en = 1'b1;
         step();
         rd_en = 1'b0;
      end
   endtask

   task automatic pop_s(input logic [20:0] exp, input string tag);
      if (empty_s) begin
         chk({20'd0, empty_s}, 21'd0, tag);
      end else begin
         chk(dout_s, exp, tag);
         rd_en_s = 1'b1;
         step();
         rd_en_s = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b0; end_frame_in = 1'b0; end_line_in = 1'b0;
      new_pixel = 1'b0; pixel = 1'b0; rd_en = 1'b0; rd_en_s = 1'b0;

      // reset state
      step(); step();
      chk({20'd0, empty}, 21'd1, "rst_empty");
      chk({20'd0, full}, 21'd0, "rst_full");
      chk({20'd0, overflow}, 21'd0, "rst_overflow");
      chk(dout, 21'd0, "rst_dout");
      chk({20'd0, empty_s}, 21'd1, "rst_empty_s");
      rst = 1'b1;
      step();

      // single line with latency probe on the first run
      pxn(1'b0, 5); pxn(1'b1, 14);
      px(1'b0);
      chk({20'd0, empty}, 21'd1, "lat_before");
      px(1'b0);
      chk({20'd0, empty}, 21'd0, "lat_empty");
      chk(dout, run(5, 18), "lat_dout");
      pxn(1'b0, 3); pxn(1'b1, 5); pxn(1'b0, 5);
      step();
      eol();
      pop(run(5, 18), "line_r0");
      pop(run(24, 28), "line_r1");
      pop(EOL, "line_eol");
      step(); step();
      chk({20'd0, empty}, 21'd1, "line_drained");

      // run still open at line end
      pxn(1'b0, 3); pxn(1'b1, 4);
      eol();
      chk({20'd0, empty}, 21'd1, "open_lat");
      pop(run(3, 6), "open_run");
      pop(EOL, "open_eol");

      // five lines closed by a frame pulse on the last one
      repeat (4) begin
         line();
         eol();
      end
      line();
      eof();
      step(); step();
      for (int i = 0; i < 5; i++) begin
         pop(run(5, 18), $sformatf("frame_l%0d_r0", i));
         pop(run(24, 28), $sformatf("frame_l%0d_r1", i));
         pop((i < 4) ? EOL : EOF, $sformatf("frame_l%0d_mark", i));
      end
      chk({20'd0, empty}, 21'd1, "frame_drained");

      // simultaneous line and frame pulses with an open run
      pxn(1'b0, 2); pxn(1'b1, 3);
      end_line_in = 1'b1; end_frame_in = 1'b1;
      step();
      end_line_in = 1'b0; end_frame_in = 1'b0;
      pop(run(2, 4), "both_run");
      pop(EOL, "both_eol");
      pop(EOF, "both_eof");

      // run reaching the saturated last column
      pxn(1'b0, 1020); pxn(1'b1, 10);
      eol();
      pop(run(1020, 1023), "sat_run");
      pop(EOL, "sat_eol");

      // read while empty is ignored and dout holds the last head
      step(); step();
      chk({20'd0, empty}, 21'd1, "idle_empty");
      chk(dout, EOL, "idle_hold");
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk({20'd0, empty}, 21'd1, "idle_rd_empty");
      chk(dout, EOL, "idle_rd_hold");

      // length-1 run at column 2 and length-3 run at columns 6..8
      pxn(1'b0, 2); px(1'b1); pxn(1'b0, 3); pxn(1'b1, 3); px(1'b0);
      eol();
`ifdef RUN_MIN_LEN_EN
      pop(run(6, 8), "minlen_keep");
`else
      pop(run(2, 2), "minlen_short");
      pop(run(6, 8), "minlen_long");
`endif
      pop(EOL, "minlen_eol");

      // overflow on the depth-4 instance
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      repeat (5) begin
         px(1'b0); px(1'b1); px(1'b1); px(1'b0);
         eol();
      end
      step(); step();
      chk({20'd0, full_s}, 21'd1, "ovf_full_s");
      chk({20'd0, overflow_s}, 21'd1, "ovf_flag_s");
      chk({20'd0, full}, 21'd0, "ovf_full_big");
      chk({20'd0, overflow}, 21'd0, "ovf_flag_big");
      pop_s(run(1, 2), "ovf_s0");
      pop_s(EOL, "ovf_s1");
      pop_s(run(1, 2), "ovf_s2");
      pop_s(EOL, "ovf_s3");
      chk({20'd0, empty_s}, 21'd1, "ovf_s_drained");
      chk({20'd0, overflow_s}, 21'd1, "ovf_sticky_s");
      for (int i = 0; i < 5; i++) begin
         pop(run(1, 2), $sformatf("ovf_big_r%0d", i));
         pop(EOL, $sformatf("ovf_big_eol%0d", i));
      end
      chk({20'd0, empty}, 21'd1, "ovf_big_drained");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
